// File: rtl/mux_rr_arbiter_pkg.sv
// Shared constants and helpers for the round-robin arbiter that owns the 4:1 mux select.
package mux_rr_arbiter_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned SEL_W   = 2;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  function automatic logic [NUM_REQ-1:0] idx2onehot(input logic [SEL_W-1:0] idx);
    logic [NUM_REQ-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_rr_pick4.sv
// Combinational round-robin search: first set req bit at or after start, optionally skipping
// mask_idx, wrapping 3->0.
module rr_pick4
  import mux_rr_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [SEL_W-1:0]   start_i,
  input  logic [SEL_W-1:0]   mask_idx_i,
  input  logic               mask_en_i,
  output logic               found_o,
  output logic [SEL_W-1:0]   idx_o
);

  logic [SEL_W-1:0] cand;

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = start_i + SEL_W'(k);
      if (!found_o && req_i[cand] && !(mask_en_i && (cand == mask_idx_i))) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter with bounded hold time, sharing a 4:1 single-bit mux among four requesters.
module mux_rr_arbiter
  import mux_rr_arbiter_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 4,
  parameter int unsigned HOLD_W   = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] d_in,
  output logic [NUM_REQ-1:0] gnt,
  output logic [SEL_W-1:0]   sel,
  output logic               busy,
  output logic               d_out
);

  localparam logic [HOLD_W-1:0] HoldMax = HOLD_W'(MAX_HOLD - 1);

  logic [0:0]         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [SEL_W-1:0]   last_q, last_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               busy_q, busy_d;

  logic               pick_found;
  logic [SEL_W-1:0]   pick_idx;
  logic [SEL_W-1:0]   pick_start;
  logic               in_grant;

  assign in_grant   = (state_q == ST_GRANT);
  // While granted, search past the owner and mask it; when idle, search past the last winner.
  assign pick_start = (in_grant ? sel_q : last_q) + SEL_W'(1);

  rr_pick4 u_pick (
    .req_i      (req),
    .start_i    (pick_start),
    .mask_idx_i (sel_q),
    .mask_en_i  (in_grant),
    .found_o    (pick_found),
    .idx_o      (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    last_d  = last_q;
    hold_d  = hold_q;
    busy_d  = busy_q;
    if (!in_grant) begin
      if (pick_found) begin
        state_d = ST_GRANT;
        gnt_d   = idx2onehot(pick_idx);
        sel_d   = pick_idx;
        last_d  = pick_idx;
        hold_d  = '0;
        busy_d  = 1'b1;
      end
    end else begin
      if (pick_found && (!req[sel_q] || (hold_q == HoldMax))) begin
        gnt_d  = idx2onehot(pick_idx);
        sel_d  = pick_idx;
        last_d = pick_idx;
        hold_d = '0;
      end else if (!req[sel_q]) begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        hold_d  = '0;
        busy_d  = 1'b0;
      end else if (hold_q != HoldMax) begin
        hold_d = hold_q + HOLD_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      last_q  <= SEL_W'(NUM_REQ - 1);
      hold_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      busy_q  <= busy_d;
    end
  end

  assign gnt   = gnt_q;
  assign sel   = sel_q;
  assign busy  = busy_q;
  assign d_out = busy_q & d_in[sel_q];

endmodule
